// File: rtl/fetch_pkg.sv
// rtl/fetch_pkg.sv - shared state encoding and FunSel constants for the fetch stage
// Purpose: state enum for instr_fetch_sequencer and the FunSel codes understood
//          by the 16-bit FunSel register (IR, PC, and the ALU-system control unit).
// Ports:   none (package).
package fetch_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_REQ_LO = 3'd1,
    ST_REQ_HI = 3'd2,
    ST_DONE   = 3'd3,
    ST_ERR    = 3'd4
  } state_t;

  localparam logic [2:0] FS_DEC     = 3'b000;
  localparam logic [2:0] FS_INC     = 3'b001;
  localparam logic [2:0] FS_LOAD    = 3'b010;
  localparam logic [2:0] FS_CLR     = 3'b011;
  localparam logic [2:0] FS_LOAD_LO = 3'b101;
  localparam logic [2:0] FS_LOAD_HI = 3'b110;
  localparam logic [2:0] FS_SEXT    = 3'b111;

endpackage

// File: rtl/instr_fetch_sequencer_if.sv
// rtl/instr_fetch_sequencer_if.sv - memory and IR/PC control bundle of the fetch stage
// Purpose: groups the byte-memory handshake and the IR/PC register controls.
// Ports:   MemRead/MemReady/MemData  byte memory handshake
//          IRFunSel/IRE/IRI          IR register control
//          PCFunSel/PCE              PC register control
// Modports: master = fetch sequencer, slave = memory plus IR/PC registers.
interface instr_fetch_sequencer_if;
  logic        MemRead;
  logic        MemReady;
  logic [7:0]  MemData;
  logic [2:0]  IRFunSel;
  logic        IRE;
  logic [15:0] IRI;
  logic [2:0]  PCFunSel;
  logic        PCE;

  modport master (
    output MemRead, IRFunSel, IRE, IRI, PCFunSel, PCE,
    input  MemReady, MemData
  );

  modport slave (
    input  MemRead, IRFunSel, IRE, IRI, PCFunSel, PCE,
    output MemReady, MemData
  );
endinterface

// File: rtl/fetch_wait_timer.sv
// rtl/fetch_wait_timer.sv - per-byte memory wait counter with limit compare
// Purpose: counts cycles spent waiting for MemReady within one REQ state.
// Ports:   Clock   rising-edge clock
//          Reset   asynchronous active-low reset, counter to 0
//          Clear   synchronous clear (has priority over Count)
//          Count   increment by one
//          Expired counter has reached WAIT_LIMIT-1 (last allowed wait cycle)
module fetch_wait_timer #(
  parameter int WAIT_LIMIT = 15
) (
  input  logic Clock,
  input  logic Reset,
  input  logic Clear,
  input  logic Count,
  output logic Expired
);

  localparam logic [7:0] LIMIT_M1 = 8'(WAIT_LIMIT - 1);

  logic [7:0] cnt;

  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset)     cnt <= 8'd0;
    else if (Clear) cnt <= 8'd0;
    else if (Count) cnt <= cnt + 8'd1;
  end

  assign Expired = (cnt == LIMIT_M1);

endmodule

// File: rtl/instr_fetch_sequencer.sv
// rtl/instr_fetch_sequencer.sv - two-byte instruction fetch into IR with PC increment
// Purpose: fetches a 16-bit instruction as two byte reads (low then high),
//          loading IR halves and incrementing PC once per byte.
// Ports:   Clock   rising-edge clock
//          Reset   asynchronous active-low reset, returns to IDLE
//          Start   fetch request, sampled only in IDLE
//          bus     memory handshake and IR/PC controls (master modport)
//          Busy    high in every state but IDLE
//          Done    one-cycle pulse, IR holds a complete instruction
//          Error   one-cycle pulse, memory did not answer within WAIT_LIMIT cycles
module instr_fetch_sequencer
  import fetch_pkg::*;
#(
  parameter int WAIT_LIMIT = 15
) (
  input  logic                    Clock,
  input  logic                    Reset,
  input  logic                    Start,
  instr_fetch_sequencer_if.master bus,
  output logic                    Busy,
  output logic                    Done,
  output logic                    Error
);

  state_t state, state_nxt;
  logic   in_req;
  logic   accept;
  logic   expired;

  assign in_req = (state == ST_REQ_LO) || (state == ST_REQ_HI);
  assign accept = in_req && bus.MemReady;

  // Clearing on every accepted byte also gives REQ_HI a fresh budget.
  fetch_wait_timer #(.WAIT_LIMIT(WAIT_LIMIT)) u_timer (
    .Clock   (Clock),
    .Reset   (Reset),
    .Clear   (!in_req || accept),
    .Count   (in_req && !bus.MemReady),
    .Expired (expired)
  );

  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) state <= ST_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt    = state;
    bus.MemRead  = 1'b0;
    bus.IRE      = 1'b0;
    bus.IRFunSel = 3'b000;  // deterministic value while IRE is low
    bus.IRI      = 16'h0000;
    bus.PCE      = 1'b0;
    bus.PCFunSel = 3'b000;  // deterministic value while PCE is low
    Busy         = 1'b1;
    Done         = 1'b0;
    Error        = 1'b0;

    case (state)
      ST_IDLE: begin
        Busy = 1'b0;
        if (Start) state_nxt = ST_REQ_LO;
      end
      ST_REQ_LO, ST_REQ_HI: begin
        bus.MemRead = 1'b1;
        if (bus.MemReady) begin
          // Byte goes straight through to IR; it lands on the edge leaving this state.
          bus.IRE      = 1'b1;
          bus.IRFunSel = (state == ST_REQ_LO) ? FS_LOAD_LO : FS_LOAD_HI;
          bus.IRI      = {8'h00, bus.MemData};
          bus.PCE      = 1'b1;
          bus.PCFunSel = FS_INC;
          state_nxt    = (state == ST_REQ_LO) ? ST_REQ_HI : ST_DONE;
        end else if (expired) begin
          state_nxt = ST_ERR;
        end
      end
      ST_DONE: begin
        Done      = 1'b1;
        state_nxt = ST_IDLE;
      end
      ST_ERR: begin
        Error     = 1'b1;
        state_nxt = ST_IDLE;
      end
      default: begin
        Busy      = 1'b0;
        state_nxt = ST_IDLE;
      end
    endcase
  end

endmodule
